// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse host receiver.
// Holds the frame FSM state encoding, frame/packet sizes and status-byte bit indices.
// No logic; imported by ps2_rx_frame, ps2_mouse_host_rx and its interface.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam int FRAME_BITS   = 11;
  localparam int PACKET_BYTES = 3;

  // Status (first packet byte) bit positions
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

endpackage

// File: rtl/ps2_mouse_host_rx_if.sv
// Decoded output bus of the PS/2 mouse receiver (bytes, packets, errors).
// master: driven by ps2_mouse_host_rx; slave: consumed by cursor/drawing logic.
// Strobes are single-cycle pulses with no backpressure; decoded fields hold between packets.
interface ps2_mouse_host_rx_if;
  import ps2_pkg::*;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       packet_valid;
  logic       btn_left;
  logic       btn_right;
  logic       btn_middle;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic       frame_err;

  modport master (
    output byte_valid, byte_data, packet_valid, btn_left, btn_right, btn_middle,
           dx, dy, x_ovf, y_ovf, frame_err
  );

  modport slave (
    input byte_valid, byte_data, packet_valid, btn_left, btn_right, btn_middle,
          dx, dy, x_ovf, y_ovf, frame_err
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes ps2_clk/ps2_dat, detects falling edges, deframes 11-bit frames.
// Latency: byte_valid/frame_err one clk after the stop-bit falling edge (pin-to-edge SYNC_STAGES+1).
// No backpressure. Ports: clk/reset, ps2 pins, pkt_busy in; registered byte_valid/byte_data/frame_err
// out, plus same-cycle byte_stb/byte_nxt/abort_stb for the packet assembler.
// Optional: PS2_RX_TIMEOUT_EN adds a stall timeout of TIMEOUT_CYCLES clk cycles.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       pkt_busy,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       byte_stb,
  output logic [7:0] byte_nxt,
  output logic       abort_stb
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shreg_q, shreg_d;
  logic                   parity_q, parity_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [7:0]             byte_data_q, byte_data_d;
  logic                   frame_err_q, frame_err_d;
  logic                   sclk, sdat, fe, good, tmo;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    sclk       = clk_sync_q[SYNC_STAGES-1];
    sdat       = dat_sync_q[SYNC_STAGES-1];
    clk_prev_d = sclk;
    fe         = clk_prev_q & ~sclk;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Saturating at TMO_MAX means the abort fires exactly once per stall.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (fe)                     tmo_cnt_d = '0;
    else if (tmo_cnt_q != TMO_MAX) tmo_cnt_d = tmo_cnt_q + TW'(1);
    tmo = !fe && (tmo_cnt_q == TMO_LAST) && ((state_q != ST_IDLE) || pkt_busy);
  end

  always_ff @(posedge clk) begin
    if (reset) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  logic unused_busy;
  assign unused_busy = pkt_busy;
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (tmo) begin
      state_d = ST_IDLE;
    end else if (fe) begin
      case (state_q)
        ST_IDLE:   if (!sdat) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic: odd parity over data+parity and a high stop bit make a good frame.
  always_comb begin
    good         = (^shreg_q ^ parity_q) & sdat;
    byte_stb     = fe && (state_q == ST_STOP) && good;
    frame_err_d  = (fe && (state_q == ST_IDLE) && sdat) ||
                   (fe && (state_q == ST_STOP) && !good) ||
                   (tmo && (state_q != ST_IDLE));
    abort_stb    = frame_err_d | tmo;
    byte_nxt     = shreg_q;
    byte_valid_d = byte_stb;
  end

  // Datapath next values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    byte_data_d = byte_data_q;
    if (fe) begin
      case (state_q)
        ST_IDLE:   bit_cnt_d = '0;
        ST_DATA: begin
          shreg_d[bit_cnt_q] = sdat;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
        ST_PARITY: parity_d = sdat;
        default:   ;
      endcase
    end
    if (byte_stb) byte_data_d = shreg_q;
  end

  // Synchronizers idle high so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= '1;
      dat_sync_q   <= '1;
      clk_prev_q   <= 1'b1;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      parity_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      clk_prev_q   <= clk_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      parity_q     <= parity_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_mouse_host_rx.sv
// PS/2 mouse host receiver: frame receiver plus 3-byte movement packet assembler.
// Latency: byte_valid and packet_valid one clk after the stop-bit falling edge, same cycle.
// No backpressure. Ports: clk, reset (sync, active-high), ps2_clk/ps2_dat pins, rx (master) bus.
// Optional: PS2_RX_TIMEOUT_EN enables stall timeout (drops partial frames and packets).
module ps2_mouse_host_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_dat,
  ps2_mouse_host_rx_if.master   rx
);

  localparam logic [1:0] IDX_LAST = 2'(PACKET_BYTES - 1);

  logic       byte_valid, frame_err, byte_stb, abort_stb, pkt_busy;
  logic [7:0] byte_data, byte_nxt;

  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] status_q, status_d;
  logic [7:0] x_q, x_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       btn_l_q, btn_l_d, btn_r_q, btn_r_d, btn_m_q, btn_m_d;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;
  logic       xo_q, xo_d, yo_q, yo_d;

  assign pkt_busy = (byte_idx_q != 2'd0);

  ps2_rx_frame #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .pkt_busy  (pkt_busy),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err),
    .byte_stb  (byte_stb),
    .byte_nxt  (byte_nxt),
    .abort_stb (abort_stb)
  );

  // Assembler runs off the frame's pre-register strobe so packet_valid
  // lines up with the third byte's byte_valid.
  always_comb begin
    byte_idx_d  = byte_idx_q;
    status_d    = status_q;
    x_d         = x_q;
    pkt_valid_d = 1'b0;
    btn_l_d     = btn_l_q;
    btn_r_d     = btn_r_q;
    btn_m_d     = btn_m_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    xo_d        = xo_q;
    yo_d        = yo_q;
    if (abort_stb) begin
      byte_idx_d = 2'd0;
    end else if (byte_stb) begin
      case (byte_idx_q)
        2'd0: begin
          // Bytes without the always-one sync bit are dropped to resync.
          if (byte_nxt[SYNC]) begin
            status_d   = byte_nxt;
            byte_idx_d = 2'd1;
          end
        end
        2'd1: begin
          x_d        = byte_nxt;
          byte_idx_d = IDX_LAST;
        end
        default: begin
          byte_idx_d  = 2'd0;
          pkt_valid_d = 1'b1;
          btn_l_d     = status_q[BTN_L];
          btn_r_d     = status_q[BTN_R];
          btn_m_d     = status_q[BTN_M];
          dx_d        = {status_q[XS], x_q};
          dy_d        = {status_q[YS], byte_nxt};
          xo_d        = status_q[XO];
          yo_d        = status_q[YO];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q  <= '0;
      status_q    <= '0;
      x_q         <= '0;
      pkt_valid_q <= 1'b0;
      btn_l_q     <= 1'b0;
      btn_r_q     <= 1'b0;
      btn_m_q     <= 1'b0;
      dx_q        <= '0;
      dy_q        <= '0;
      xo_q        <= 1'b0;
      yo_q        <= 1'b0;
    end else begin
      byte_idx_q  <= byte_idx_d;
      status_q    <= status_d;
      x_q         <= x_d;
      pkt_valid_q <= pkt_valid_d;
      btn_l_q     <= btn_l_d;
      btn_r_q     <= btn_r_d;
      btn_m_q     <= btn_m_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      xo_q        <= xo_d;
      yo_q        <= yo_d;
    end
  end

  assign rx.byte_valid   = byte_valid;
  assign rx.byte_data    = byte_data;
  assign rx.frame_err    = frame_err;
  assign rx.packet_valid = pkt_valid_q;
  assign rx.btn_left     = btn_l_q;
  assign rx.btn_right    = btn_r_q;
  assign rx.btn_middle   = btn_m_q;
  assign rx.dx           = dx_q;
  assign rx.dy           = dy_q;
  assign rx.x_ovf        = xo_q;
  assign rx.y_ovf        = yo_q;

endmodule

// File: tb/tb_ps2_mouse_host_rx.sv
// Testbench for ps2_mouse_host_rx: drives PS/2 frames like a mouse and checks
// byte, packet and error outputs against a byte/packet-level model every cycle.
module tb_ps2_mouse_host_rx;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;

  ps2_mouse_host_rx_if rx_if ();

  ps2_mouse_host_rx #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected events in arrival order: a good byte or a frame error.
  typedef struct {
    bit         is_err;
    logic [7:0] b;
  } ev_t;
  ev_t evq[$];

  // Packet-level model state and held expected outputs
  int         m_idx = 0;
  logic [7:0] m_status = '0, m_x = '0;
  logic [7:0] h_byte = '0;
  logic [2:0] h_btn = '0;
  logic [8:0] h_dx = '0, h_dy = '0;
  logic       h_xo = 1'b0, h_yo = 1'b0;
  int         pv_count = 0;
  int         err_count = 0;

  always begin
    bit         exp_pkt;
    logic [7:0] b;
    @(posedge clk);
    #2;
    exp_pkt = 1'b0;
    if (reset) begin
      evq.delete();
      m_idx = 0; h_byte = '0; h_btn = '0; h_dx = '0; h_dy = '0; h_xo = 1'b0; h_yo = 1'b0;
    end
    if (rx_if.byte_valid) begin
      check("byte_expected", 16'(evq.size() > 0 && !evq[0].is_err), 16'd1);
      if (evq.size() > 0 && !evq[0].is_err) begin
        b = evq[0].b;
        void'(evq.pop_front());
        h_byte = b;
        if (m_idx == 0) begin
          if (b[3]) begin m_status = b; m_idx = 1; end
        end else if (m_idx == 1) begin
          m_x = b; m_idx = 2;
        end else begin
          m_idx = 0; exp_pkt = 1'b1;
          h_btn = m_status[2:0];
          h_dx  = {m_status[4], m_x};
          h_dy  = {m_status[5], b};
          h_xo  = m_status[6];
          h_yo  = m_status[7];
        end
      end
    end
    if (rx_if.frame_err) begin
      err_count++;
      check("err_expected", 16'(evq.size() > 0 && evq[0].is_err), 16'd1);
      if (evq.size() > 0 && evq[0].is_err) void'(evq.pop_front());
      m_idx = 0;
    end
    if (rx_if.packet_valid) pv_count++;
    check("packet_valid", 16'(rx_if.packet_valid), 16'(exp_pkt));
    check("byte_data", 16'(rx_if.byte_data), 16'(h_byte));
    check("buttons", 16'({rx_if.btn_middle, rx_if.btn_right, rx_if.btn_left}), 16'(h_btn));
    check("dx", 16'(rx_if.dx), 16'(h_dx));
    check("dy", 16'(rx_if.dy), 16'(h_dy));
    check("ovf", 16'({rx_if.y_ovf, rx_if.x_ovf}), 16'({h_yo, h_xo}));
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit cell: data set while clock high, 50 cycles high, 50 low.
  task automatic send_bit(input logic v);
    ps2_dat = v;
    wait_cycles(50);
    ps2_clk = 1'b0;
    wait_cycles(50);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_parity);
    ev_t        e;
    logic       par;
    par = ~^b;
    if (bad_parity) par = ~par;
    e.is_err = bad_parity;
    e.b      = b;
    evq.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_cycles(200);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    ps2_dat = 1'b1;
  endtask

  task automatic drained(input string name);
    wait_cycles(20);
    check(name, 16'(evq.size()), 16'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int pv0, er0;

  initial begin
    wait_cycles(5);
    // Reset state, literal
    check("rst_dx", 16'(rx_if.dx), 16'h0);
    check("rst_byte_valid", 16'(rx_if.byte_valid), 16'h0);
    reset = 1'b0;
    wait_cycles(10);

    // Left button, +2, +1
    pv0 = pv_count;
    send_frame(8'h09, 0); send_frame(8'h02, 0); send_frame(8'h01, 0);
    drained("t1_drained");
    check("t1_pv", 16'(pv_count - pv0), 16'd1);
    check("t1_btn_left", 16'(rx_if.btn_left), 16'd1);
    check("t1_dx", 16'(rx_if.dx), 16'h002);
    check("t1_dy", 16'(rx_if.dy), 16'h001);

    // Negative deltas
    send_frame(8'h38, 0); send_frame(8'hFE, 0); send_frame(8'hFF, 0);
    drained("t2_drained");
    check("t2_dx", 16'(rx_if.dx), 16'h1FE);
    check("t2_dy", 16'(rx_if.dy), 16'h1FF);
    check("t2_btn", 16'({rx_if.btn_middle, rx_if.btn_right, rx_if.btn_left}), 16'h0);
    check("t2_ovf", 16'({rx_if.y_ovf, rx_if.x_ovf}), 16'h0);

    // Parity error then a good packet
    er0 = err_count;
    send_frame(8'h08, 1);
    drained("t3_err_drained");
    check("t3_err_count", 16'(err_count - er0), 16'd1);
    check("t3_byte_data_held", 16'(rx_if.byte_data), 16'hFF);
    send_frame(8'h0C, 0); send_frame(8'h07, 0); send_frame(8'h03, 0);
    drained("t3_drained");
    check("t3_dx", 16'(rx_if.dx), 16'h007);
    check("t3_btn_middle", 16'(rx_if.btn_middle), 16'd1);

    // Leading byte without sync bit
    pv0 = pv_count;
    send_frame(8'h00, 0);
    send_frame(8'h09, 0); send_frame(8'h02, 0); send_frame(8'h01, 0);
    drained("t4_drained");
    check("t4_pv", 16'(pv_count - pv0), 16'd1);
    check("t4_dx", 16'(rx_if.dx), 16'h002);

    // Stall after data bit 4
    er0 = err_count;
    send_partial(8'h55, 5);
`ifdef PS2_RX_TIMEOUT_EN
    begin
      ev_t e;
      e.is_err = 1'b1;
      e.b      = 8'h00;
      evq.push_back(e);
    end
    wait_cycles(6000);
    drained("t5_drained");
    check("t5_err_count", 16'(err_count - er0), 16'd1);
`else
    wait_cycles(6000);
    drained("t5_drained");
    check("t5_err_count", 16'(err_count - er0), 16'd0);
    pulse_reset();
    wait_cycles(5);
`endif
    send_frame(8'h19, 0); send_frame(8'h04, 0); send_frame(8'h06, 0);
    drained("t5_pkt_drained");
    check("t5_dx", 16'(rx_if.dx), 16'h104);
    check("t5_dy", 16'(rx_if.dy), 16'h006);

    // Reset in the middle of the second byte
    send_frame(8'h09, 0);
    send_partial(8'h02, 4);
    wait_cycles(30);
    pulse_reset();
    wait_cycles(2);
    check("t6_rst_dx", 16'(rx_if.dx), 16'h0);
    check("t6_rst_btn", 16'({rx_if.btn_middle, rx_if.btn_right, rx_if.btn_left}), 16'h0);
    check("t6_rst_byte", 16'(rx_if.byte_data), 16'h0);
    pv0 = pv_count;
    send_frame(8'h0A, 0); send_frame(8'h05, 0); send_frame(8'h03, 0);
    drained("t6_drained");
    check("t6_pv", 16'(pv_count - pv0), 16'd1);
    check("t6_dx", 16'(rx_if.dx), 16'h005);
    check("t6_dy", 16'(rx_if.dy), 16'h003);
    check("t6_btn_right", 16'(rx_if.btn_right), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
